// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if
// Bundles the serial-side and byte-side signals of the UART byte receiver.
//   rx        serial line, idle high (driven by master)
//   en_rx     receive enable from the downstream controller (driven by master)
//   rx_data   last correctly received byte (driven by slave)
//   rx_d_val  one-cycle strobe, rx_data newly valid (driven by slave)
//   rx_busy   a frame is in progress (driven by slave)
//   frame_err most recent frame had a zero stop bit (driven by slave)
interface uart_rx_byte_if;
  logic       rx;
  logic       en_rx;
  logic [7:0] rx_data;
  logic       rx_d_val;
  logic       rx_busy;
  logic       frame_err;

  modport master (
    output rx, en_rx,
    input  rx_data, rx_d_val, rx_busy, frame_err
  );

  modport slave (
    input  rx, en_rx,
    output rx_data, rx_d_val, rx_busy, frame_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART receiver feeding the operand/opcode collector. Samples every bit
// at its mid-point, strobes each good byte for one cycle, flags framing
// errors and rejects start-bit glitches.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active-high (in reset while rst_n=1)
//   bus    uart_rx_byte_if.slave: rx, en_rx in; rx_data, rx_d_val,
//          rx_busy, frame_err out
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line while en_rx=1
// START | counting to the start-bit mid-point to confirm the start bit
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit, then strobing the byte or flagging an error
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_byte_if.slave bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dval_q, dval_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, rx_s_q, prev_q;
  logic          fall_edge;

  assign fall_edge = prev_q & ~rx_s_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= bus.rx;
      rx_s_q  <= sync1_q;
      prev_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dval_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en_rx && fall_edge) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // line back high at the start-bit mid-point means it was a glitch
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // leave at the stop-bit mid-point so a start edge half a bit later is caught
          state_d = IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            dval_d = 1'b1;
            ferr_d = 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_d_val  = dval_q;
  assign bus.rx_busy   = (state_q != IDLE);
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
// Self-checking bench for uart_rx_byte with CLKS_PER_BIT=16. Frames are
// driven bit by bit on the serial line; a frame-level reference model
// predicts which bytes must be strobed, the resulting rx_data/frame_err,
// and the pin-to-strobe latency.
module tb_uart_rx_byte;
  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  // synchroniser (2) + start edge to strobe
  localparam int LAT = 2 + HALF + 9 * CPB + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   start_cyc;
  int   total;
  int   bad;
  logic prev_dval;
  logic [7:0] exp_data;
  logic       exp_ferr;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         lat_q[$];

  uart_rx_byte_if bif ();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial prev_dval = 1'b0;
  always @(negedge clk) begin
    if (bif.rx_d_val === 1'b1) begin
      got_q.push_back(bif.rx_data);
      lat_q.push_back(cyc - start_cyc);
      chk("dval_one_cycle", {31'd0, prev_dval}, 32'd0);
    end
    prev_dval <= bif.rx_d_val;
  end

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic post_check();
    chk("rx_data", {24'd0, bif.rx_data}, {24'd0, exp_data});
    chk("frame_err", {31'd0, bif.frame_err}, {31'd0, exp_ferr});
    chk("busy_idle", {31'd0, bif.rx_busy}, 32'd0);
  endtask

  task automatic flush();
    int n;
    chk("n_strobes", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("byte", {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      chk("latency", lat_q[i], LAT);
    end
    got_q.delete();
    exp_q.delete();
    lat_q.delete();
  endtask

  // drop_bit / rst_bit: data-bit index at which en_rx falls / reset pulses (-1 = never)
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit en,
                            input int drop_bit, input int rst_bit);
    logic [9:0] bits;
    bit accepted;
    bit aborted;
    bit busy_any;
    bits = {stop, b, 1'b0};
    accepted = en;
    aborted = 1'b0;
    busy_any = 1'b0;
    @(negedge clk);
    bif.en_rx = en;
    @(negedge clk);
    start_cyc = cyc;
    for (int k = 0; k < 10 && !aborted; k++) begin
      bif.rx = bits[k];
      if (k >= 1 && (k - 1) == drop_bit) bif.en_rx = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        busy_any = busy_any | bif.rx_busy;
        if (k >= 1 && k <= 8 && c == HALF)
          chk("busy_mid_bit", {31'd0, bif.rx_busy}, {31'd0, accepted});
        if (k >= 1 && (k - 1) == rst_bit && c == 4) begin
          rst_n = 1'b1;
          #1;
          chk("reset_outputs", {20'd0, bif.rx_data, bif.rx_d_val, bif.rx_busy, bif.frame_err}, 32'd0);
          bif.rx = 1'b1;
          @(negedge clk);
          rst_n = 1'b0;
          aborted = 1'b1;
          exp_data = 8'h00;
          exp_ferr = 1'b0;
          break;
        end
      end
    end
    bif.rx = 1'b1;
    if (!aborted) begin
      chk("busy_any", {31'd0, busy_any}, {31'd0, accepted});
      if (accepted) begin
        if (stop) begin
          exp_q.push_back(b);
          exp_data = b;
          exp_ferr = 1'b0;
        end else begin
          exp_ferr = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] rb;
    total = 0;
    bad = 0;
    start_cyc = 0;
    exp_data = 8'h00;
    exp_ferr = 1'b0;
    rst_n = 1'b1;
    bif.rx = 1'b1;
    bif.en_rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_state", {20'd0, bif.rx_data, bif.rx_d_val, bif.rx_busy, bif.frame_err}, 32'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // single frame
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    flush();

    // back-to-back with one idle bit
    send_frame(8'h12, 1'b1, 1'b1, -1, -1);
    idle_bits(1);
    send_frame(8'h34, 1'b1, 1'b1, -1, -1);
    idle_bits(1);
    send_frame(8'h05, 1'b1, 1'b1, -1, -1);
    idle_bits(1);
    send_frame(8'h01, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    flush();

    // glitch then valid frame
    @(negedge clk);
    bif.en_rx = 1'b1;
    bif.rx = 1'b0;
    repeat (4) @(negedge clk);
    bif.rx = 1'b1;
    busy_cnt = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (bif.rx_busy) busy_cnt++;
    end
    chk("glitch_busy_le9", {31'd0, (busy_cnt > 0 && busy_cnt <= 9)}, 32'd1);
    chk("glitch_no_strobe", got_q.size(), 0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    flush();

    // framing error between good frames
    send_frame(8'h11, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    send_frame(8'h22, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    flush();

    // enable handling
    send_frame(8'h77, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    post_check();
    flush();
    send_frame(8'h66, 1'b1, 1'b1, 2, -1);
    idle_bits(2);
    post_check();
    flush();

    // reset mid-frame
    send_frame(8'hFF, 1'b1, 1'b1, -1, 3);
    idle_bits(2);
    post_check();
    flush();
    send_frame(8'h0F, 1'b1, 1'b1, -1, -1);
    idle_bits(2);
    post_check();
    flush();

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(4) == 0) ? int'($urandom_range(7)) : -1, -1);
      idle_bits(1 + int'($urandom_range(2)));
      post_check();
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
